oht_mc: RTL

Multi-channel online health test (OHT) for the entropy-source front end. It takes N_CH raw comparator/ADC bit streams and runs a repetition count test (RCT) and an adaptive proportion test (APT) on each one. Each channel has its own bias-calibration trim and its own intermittent/permanent failure tracking. Bits from healthy channels are XOR-combined, packed into SAMPLE_SIZE-bit words and buffered in a first-word-fall-through FIFO for the conditioner.

---
 rtl/oht_mc.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/oht_mc.sv
// oht_mc: multi-channel online health test for the entropy-source front end.
//
// Each channel runs a repetition count test (RCT) and an adaptive proportion
// test (APT) on its raw bit stream. Each channel also tracks its own failures
// and its own bias-calibration trim. Bits from channels without a permanent
// failure are XOR-combined and packed MSB-first into SAMPLE_SIZE-bit words.
// Those words go into a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   adc_in[N_CH]       one raw bit per channel
//   adc_en             sample strobe
//   deque              pop the FIFO head
//   inter_fail[N_CH]   one-cycle pulse per failure event
//   perm_fail[N_CH]    sticky permanent failure (cleared only by rst)
//   checked_noise      FIFO head word, 0 when empty
//   good_entropy_out   FIFO not empty
//   full, empty        FIFO occupancy flags
//   calibration_arr_n  per-channel trim adding ones,  channel i at [8i+7:8i]
//   calibration_arr_p  per-channel trim adding zeros, same packing
//
// Handshake: adc_in is consumed on every clk where adc_en=1; there is no
// back-pressure, so a word completed while the FIFO is full is lost unless
// deque is high in that same cycle. deque=1 pops the head at the clk edge
// (ignored when empty); checked_noise shows the new head one clk later.
module oht_mc #(
    parameter int N_CH        = 2,
    parameter int SAMPLE_SIZE = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int RCT_CUTOFF  = 8,
    parameter int APT_WINDOW  = 64,
    parameter int APT_CUTOFF  = 48,
    parameter int FAIL_LIMIT  = 3,
    parameter int CAL_TOL     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        adc_in,
    input  logic                   adc_en,
    input  logic                   deque,
    output logic [N_CH-1:0]        inter_fail,
    output logic [N_CH-1:0]        perm_fail,
    output logic [SAMPLE_SIZE-1:0] checked_noise,
    output logic                   good_entropy_out,
    output logic                   full,
    output logic                   empty,
    output logic [8*N_CH-1:0]      calibration_arr_n,
    output logic [8*N_CH-1:0]      calibration_arr_p
);

    localparam int RCT_W  = $clog2(RCT_CUTOFF + 1);
    localparam int WIN_W  = (APT_WINDOW > 1) ? $clog2(APT_WINDOW) : 1;
    localparam int ONES_W = $clog2(APT_WINDOW + 1);
    localparam int FAIL_W = $clog2(FAIL_LIMIT + 1);
    localparam int BIT_W  = (SAMPLE_SIZE > 1) ? $clog2(SAMPLE_SIZE) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [RCT_W-1:0]  RCT_MAX  = RCT_W'(RCT_CUTOFF);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(APT_WINDOW - 1);
    localparam logic [ONES_W-1:0] APT_HI   = ONES_W'(APT_CUTOFF);
    localparam logic [ONES_W-1:0] APT_LO   = ONES_W'(APT_WINDOW - APT_CUTOFF);
    localparam logic [ONES_W-1:0] CAL_HI   = ONES_W'(APT_WINDOW / 2 + CAL_TOL);
    localparam logic [ONES_W-1:0] CAL_LO   = ONES_W'(APT_WINDOW / 2 - CAL_TOL);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(FAIL_LIMIT);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(SAMPLE_SIZE - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

    // Per-channel health state
    logic [N_CH-1:0]   last_bit;
    logic [RCT_W-1:0]  rct_cnt  [N_CH];
    logic [WIN_W-1:0]  win_cnt  [N_CH];
    logic [ONES_W-1:0] ones     [N_CH];
    logic [FAIL_W-1:0] fail_cnt [N_CH];

    // Per-channel combinational evaluation of the current sample
    logic [RCT_W-1:0]  rct_inc  [N_CH];
    logic [ONES_W-1:0] ones_tot [N_CH];
    logic [N_CH-1:0]   win_end;
    logic [N_CH-1:0]   rct_fail;
    logic [N_CH-1:0]   apt_fail;
    logic [N_CH-1:0]   fail_ev;

    // Data path and FIFO
    logic [SAMPLE_SIZE-1:0] shreg;
    logic [BIT_W-1:0]       bit_cnt;
    logic [SAMPLE_SIZE-1:0] word_next;
    logic                   comb_bit;
    logic                   take;
    logic                   push;
    logic [SAMPLE_SIZE-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr, rd_nxt;
    logic [CNT_W-1:0]       count, count_nxt;
    logic                   pop, push_ok;
    logic [SAMPLE_SIZE-1:0] head_nxt;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // A run restarts at 1 on a change; after reset or an RCT clear the
            // count is 0, so the next sample lands on 1 either way.
            rct_inc[i]  = (adc_in[i] == last_bit[i]) ? rct_cnt[i] + RCT_W'(1) : RCT_W'(1);
            ones_tot[i] = ones[i] + ONES_W'(adc_in[i]);
            win_end[i]  = adc_en && (win_cnt[i] == WIN_LAST);
            rct_fail[i] = adc_en && (rct_inc[i] == RCT_MAX);
            apt_fail[i] = win_end[i] && ((ones_tot[i] > APT_HI) || (ones_tot[i] < APT_LO));
            // Simultaneous RCT and APT failures are one event.
            fail_ev[i]  = rct_fail[i] || apt_fail[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inter_fail        <= '0;
            perm_fail         <= '0;
            last_bit          <= '0;
            calibration_arr_n <= '0;
            calibration_arr_p <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rct_cnt[i]  <= '0;
                win_cnt[i]  <= '0;
                ones[i]     <= '0;
                fail_cnt[i] <= '0;
            end
        end else begin
            inter_fail <= fail_ev;
            for (int i = 0; i < N_CH; i++) begin
                if (adc_en) begin
                    last_bit[i] <= adc_in[i];
                    rct_cnt[i]  <= rct_fail[i] ? RCT_W'(0) : rct_inc[i];
                    if (win_end[i]) begin
                        win_cnt[i] <= '0;
                        ones[i]    <= '0;
                    end else begin
                        win_cnt[i] <= win_cnt[i] + WIN_W'(1);
                        ones[i]    <= ones_tot[i];
                    end
                end
                if (fail_ev[i]) begin
                    if (fail_cnt[i] != FAIL_MAX)
                        fail_cnt[i] <= fail_cnt[i] + FAIL_W'(1);
                    if (fail_cnt[i] >= FAIL_MAX - FAIL_W'(1))
                        perm_fail[i] <= 1'b1;
                end
                // The trim first undoes the opposite trim, then pushes further.
                // It is frozen once the channel has failed permanently.
                if (win_end[i] && !perm_fail[i]) begin
                    if (ones_tot[i] > CAL_HI) begin
                        if (calibration_arr_n[8*i +: 8] != 8'd0)
                            calibration_arr_n[8*i +: 8] <= calibration_arr_n[8*i +: 8] - 8'd1;
                        else if (calibration_arr_p[8*i +: 8] != 8'hff)
                            calibration_arr_p[8*i +: 8] <= calibration_arr_p[8*i +: 8] + 8'd1;
                    end else if (ones_tot[i] < CAL_LO) begin
                        if (calibration_arr_p[8*i +: 8] != 8'd0)
                            calibration_arr_p[8*i +: 8] <= calibration_arr_p[8*i +: 8] - 8'd1;
                        else if (calibration_arr_n[8*i +: 8] != 8'hff)
                            calibration_arr_n[8*i +: 8] <= calibration_arr_n[8*i +: 8] + 8'd1;
                    end
                end
            end
        end
    end

    // Word assembly: any failure event discards the partial word and this sample.
    always_comb begin
        comb_bit  = ^(adc_in & ~perm_fail);
        take      = adc_en && !(|fail_ev) && (|(~perm_fail));
        word_next = {shreg[SAMPLE_SIZE-2:0], comb_bit};
        push      = take && (bit_cnt == BIT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (adc_en) begin
            if (|fail_ev) begin
                bit_cnt <= '0;
            end else if (take) begin
                shreg   <= word_next;
                bit_cnt <= push ? BIT_W'(0) : bit_cnt + BIT_W'(1);
            end
        end
    end

    // FIFO: the pop is handled before the push, so a push into a full FIFO
    // succeeds when deque is high in the same cycle.
    always_comb begin
        pop       = deque && (count != '0);
        push_ok   = push && ((count != CNT_FULL) || pop);
        count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);
        rd_nxt    = pop ? ((rd_ptr == PTR_LAST) ? PTR_W'(0) : rd_ptr + PTR_W'(1)) : rd_ptr;
        // The registered head must already reflect a word written this cycle
        // when that word lands in the slot that becomes the head.
        if (count_nxt == '0)
            head_nxt = '0;
        else if (push_ok && (wr_ptr == rd_nxt))
            head_nxt = word_next;
        else
            head_nxt = mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= word_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            checked_noise    <= '0;
            empty            <= 1'b1;
            full             <= 1'b0;
            good_entropy_out <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= (wr_ptr == PTR_LAST) ? PTR_W'(0) : wr_ptr + PTR_W'(1);
            rd_ptr           <= rd_nxt;
            count            <= count_nxt;
            checked_noise    <= head_nxt;
            empty            <= (count_nxt == '0);
            full             <= (count_nxt == CNT_FULL);
            good_entropy_out <= (count_nxt != '0);
        end
    end

endmodule
